// File: rtl/riscv_defines.sv
// Shared RV32I constants and the instruction-memory responder state type.
package riscv_defines;

    localparam int unsigned WORD_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        WAIT
    } resp_state_e;

endpackage

// File: rtl/instr_mem_array.sv
// Single-port synchronous-read instruction RAM with a separate preload write port.
// Kept as its own module so FPGA builds can substitute a vendor RAM macro.
module instr_mem_array
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WIDTH       = WORD_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [WIDTH-1:0]               rdata
);

    logic [WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the instruction-fetch req/gnt/rvalid protocol:
// grant with optional wait-states, synchronous read, fixed-latency in-order return.
module instr_mem_responder
    import riscv_defines::*;
#(
    parameter int unsigned           DEPTH_WORDS = 1024,
    parameter int unsigned           LATENCY     = 1,
    parameter int unsigned           GNT_WAIT    = 0,
    parameter logic [WORD_WIDTH-1:0] NOP_WORD    = NOP_INSTR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           instr_req_i,
    input  logic [WORD_WIDTH-1:0]          instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [WORD_WIDTH-1:0]          instr_rdata_o,
    output logic                           instr_err_o,
    input  logic                           load_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [WORD_WIDTH-1:0]          load_wdata_i,
    output logic                           busy_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    if (LATENCY == 0 || LATENCY > 4) begin : g_bad_latency
        $error("instr_mem_responder: LATENCY must be in 1..4");
    end
    if (GNT_WAIT > 7) begin : g_bad_gnt_wait
        $error("instr_mem_responder: GNT_WAIT must be in 0..7");
    end
    if ((32'd1 << AW) != DEPTH_WORDS) begin : g_bad_depth
        $error("instr_mem_responder: DEPTH_WORDS must be a power of two");
    end

    resp_state_e            state;
    logic [2:0]             wait_cnt;
    logic                   fsm_allows;
    logic                   gnt;
    logic                   out_of_range;
    logic                   addr_err;
    logic [WORD_WIDTH-1:0]  ram_rdata;
    logic [WORD_WIDTH-1:0]  last_data;
    logic [LATENCY-1:0]     pipe_valid;
    logic [LATENCY-1:0]     pipe_err;

    always_comb begin
        if (state == IDLE) begin
            fsm_allows = (GNT_WAIT == 0);
        end else begin
            fsm_allows = (wait_cnt == 3'(GNT_WAIT));
        end
        gnt = fsm_allows && instr_req_i && !load_we_i;
    end

    // Preload freezes the wait-state sequence; dropping req always abandons it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else if (!instr_req_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else if (!load_we_i) begin
            case (state)
                IDLE: begin
                    if (GNT_WAIT != 0) begin
                        state    <= WAIT;
                        wait_cnt <= 3'd1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'(GNT_WAIT)) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    if (AW + 2 < WORD_WIDTH) begin : g_range
        always_comb out_of_range = |instr_addr_i[WORD_WIDTH-1:AW+2];
    end else begin : g_full_range
        always_comb out_of_range = 1'b0;
    end

    always_comb addr_err = (instr_addr_i[1:0] != 2'b00) || out_of_range;

    instr_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WIDTH       (WORD_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (load_we_i),
        .waddr (load_addr_i),
        .wdata (load_wdata_i),
        .re    (gnt),
        .raddr (instr_addr_i[2 +: AW]),
        .rdata (ram_rdata)
    );

    // Stage registers only advance with a valid entry so the last stage holds
    // the previous response while rvalid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
        end else begin
            pipe_valid[0] <= gnt;
            if (gnt) begin
                pipe_err[0] <= addr_err;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_err[i] <= pipe_err[i-1];
                end
            end
        end
    end

    // The RAM read register is stage 0 of the data path; dly[i] pairs with pipe_valid[i+1].
    if (LATENCY == 1) begin : g_direct
        always_comb last_data = ram_rdata;
    end else begin : g_delay
        logic [WORD_WIDTH-1:0] dly [LATENCY-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                    dly[i] <= '0;
                end
            end else begin
                if (pipe_valid[0]) begin
                    dly[0] <= ram_rdata;
                end
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    if (pipe_valid[i]) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end
        end

        always_comb last_data = dly[LATENCY-2];
    end

    always_comb begin
        instr_gnt_o    = gnt;
        instr_rvalid_o = pipe_valid[LATENCY-1];
        instr_err_o    = pipe_valid[LATENCY-1] & pipe_err[LATENCY-1];
        instr_rdata_o  = pipe_err[LATENCY-1] ? NOP_WORD : last_data;
        busy_o         = |pipe_valid;
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: three instances cover base timing,
// wait-state granting and a deeper latency pipeline with mid-flight reset.
module tb_instr_mem_responder;
    import riscv_defines::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_we = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [31:0] load_wdata = '0;

    logic        a_req = 1'b0, b_req = 1'b0, c_req = 1'b0;
    logic [31:0] a_addr = '0, b_addr = '0, c_addr = '0;
    logic        a_gnt, a_rvalid, a_err, a_busy;
    logic        b_gnt, b_rvalid, b_err, b_busy;
    logic        c_gnt, c_rvalid, c_err, c_busy;
    logic [31:0] a_rdata, b_rdata, c_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .GNT_WAIT(0)) u_a (
        .clk(clk), .rst(rst), .instr_req_i(a_req), .instr_addr_i(a_addr),
        .instr_gnt_o(a_gnt), .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata),
        .instr_err_o(a_err), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .busy_o(a_busy)
    );

    instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .GNT_WAIT(3)) u_b (
        .clk(clk), .rst(rst), .instr_req_i(b_req), .instr_addr_i(b_addr),
        .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata),
        .instr_err_o(b_err), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .busy_o(b_busy)
    );

    instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .GNT_WAIT(0)) u_c (
        .clk(clk), .rst(rst), .instr_req_i(c_req), .instr_addr_i(c_addr),
        .instr_gnt_o(c_gnt), .instr_rvalid_o(c_rvalid), .instr_rdata_o(c_rdata),
        .instr_err_o(c_err), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .busy_o(c_busy)
    );

    typedef struct {
        logic        we;
        logic [3:0]  laddr;
        logic [31:0] wdata;
        logic        req;
        logic [31:0] addr;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic gnt, input logic rv, input logic [31:0] rd);
        check({tag, "_gnt"}, {31'b0, b_gnt}, {31'b0, gnt});
        check({tag, "_rvalid"}, {31'b0, b_rvalid}, {31'b0, rv});
        if (rv) check({tag, "_rdata"}, b_rdata, rd);
    endtask

    task automatic chk_c(input string tag, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic busy);
        check({tag, "_gnt"}, {31'b0, c_gnt}, {31'b0, gnt});
        check({tag, "_rvalid"}, {31'b0, c_rvalid}, {31'b0, rv});
        check({tag, "_rdata"}, c_rdata, rd);
        check({tag, "_err"}, {31'b0, c_err}, 32'd0);
        check({tag, "_busy"}, {31'b0, c_busy}, {31'b0, busy});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          we laddr wdata       req addr      gnt rv rdata        err busy
        vecs[0]  = '{1'b1, 4'd0, 32'h11, 1'b0, 32'd0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd1, 32'h22, 1'b0, 32'd0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd2, 32'h33, 1'b0, 32'd0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd3, 32'h44, 1'b0, 32'd0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd0, 32'h0,  1'b1, 32'd0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 32'h0,  1'b1, 32'd4,  1'b1, 1'b1, 32'h11, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 4'd0, 32'h0,  1'b1, 32'd8,  1'b1, 1'b1, 32'h22, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 4'd0, 32'h0,  1'b1, 32'd12, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 4'd0, 32'h0,  1'b1, 32'd2,  1'b1, 1'b1, 32'h44, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 4'd0, 32'h0,  1'b1, 32'd64, 1'b1, 1'b1, 32'h13, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 32'h0,  1'b0, 32'd0,  1'b0, 1'b1, 32'h13, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 4'd0, 32'h0,  1'b0, 32'd0,  1'b0, 1'b0, 32'h13, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 4'd2, 32'hAB, 1'b1, 32'd8,  1'b0, 1'b0, 32'h13, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'd0, 32'h0,  1'b1, 32'd8,  1'b1, 1'b0, 32'h13, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'd0, 32'h0,  1'b0, 32'd0,  1'b0, 1'b1, 32'hAB, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 4'd0, 32'h0,  1'b0, 32'd0,  1'b0, 1'b0, 32'hAB, 1'b0, 1'b0};

        #3;
        check("rst_rvalid", {31'b0, a_rvalid}, 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_err", {31'b0, a_err}, 32'd0);
        check("rst_busy", {31'b0, c_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_we    = vecs[i].we;
            load_addr  = vecs[i].laddr;
            load_wdata = vecs[i].wdata;
            a_req      = vecs[i].req;
            a_addr     = vecs[i].addr;
            #1;
            check($sformatf("v%0d_gnt", i), {31'b0, a_gnt}, {31'b0, vecs[i].gnt});
            check($sformatf("v%0d_rvalid", i), {31'b0, a_rvalid}, {31'b0, vecs[i].rvalid});
            check($sformatf("v%0d_rdata", i), a_rdata, vecs[i].rdata);
            check($sformatf("v%0d_err", i), {31'b0, a_err}, {31'b0, vecs[i].err});
            check($sformatf("v%0d_busy", i), {31'b0, a_busy}, {31'b0, vecs[i].busy});
        end

        // Wait-states: grant lands in the 4th cycle of a held request.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); b_req = 1'b1; b_addr = 32'd4; #1;
            chk_b($sformatf("bw%0d", k), k == 3, 1'b0, 32'h0);
        end
        @(negedge clk); b_req = 1'b0; #1;
        chk_b("bw_resp", 1'b0, 1'b1, 32'h22);

        // Abandoned request restarts the wait count from scratch.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); b_req = 1'b1; #1;
            chk_b($sformatf("bd%0d", k), 1'b0, 1'b0, 32'h0);
        end
        @(negedge clk); b_req = 1'b0; #1;
        chk_b("bd_drop", 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); b_req = 1'b1; #1;
            chk_b($sformatf("br%0d", k), k == 3, 1'b0, 32'h0);
        end
        @(negedge clk); b_req = 1'b0; #1;
        chk_b("br_resp", 1'b0, 1'b1, 32'h22);
        @(negedge clk); #1;
        chk_b("br_idle", 1'b0, 1'b0, 32'h0);

        // LATENCY=3: three back-to-back grants, in-order return.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); c_req = 1'b1; c_addr = 32'(4 * k); #1;
            chk_c($sformatf("cg%0d", k), 1'b1, 1'b0, 32'h0, k > 0);
        end
        @(negedge clk); c_req = 1'b0; #1;
        chk_c("cr0", 1'b0, 1'b1, 32'h11, 1'b1);
        @(negedge clk); #1;
        chk_c("cr1", 1'b0, 1'b1, 32'h22, 1'b1);
        @(negedge clk); #1;
        chk_c("cr2", 1'b0, 1'b1, 32'hAB, 1'b1);
        @(negedge clk); #1;
        chk_c("cr_done", 1'b0, 1'b0, 32'hAB, 1'b0);

        // Reset with two responses in flight discards them.
        @(negedge clk); c_req = 1'b1; c_addr = 32'd0; #1;
        chk_c("cx0", 1'b1, 1'b0, 32'hAB, 1'b0);
        @(negedge clk); c_addr = 32'd4; #1;
        chk_c("cx1", 1'b1, 1'b0, 32'hAB, 1'b1);
        @(negedge clk); c_req = 1'b0; #1;
        chk_c("cx_inflight", 1'b0, 1'b0, 32'hAB, 1'b1);
        #1; rst = 1'b1; #1;
        chk_c("cx_rst", 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk_c($sformatf("cx_quiet%0d", k), 1'b0, 1'b0, 32'h0, 1'b0);
        end
        @(negedge clk); c_req = 1'b1; c_addr = 32'd12; #1;
        chk_c("cn_gnt", 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); c_req = 1'b0; #1;
        chk_c("cn1", 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); #1;
        chk_c("cn2", 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); #1;
        chk_c("cn3", 1'b0, 1'b1, 32'h44, 1'b1);
        @(negedge clk); #1;
        chk_c("cn4", 1'b0, 1'b0, 32'h44, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
